// File: rtl/sync_debounce.sv
// Synchronises a bouncy asynchronous input into clk and accepts a new level only after
// it has held for STABLE_CYCLES samples. Provides registered edge strobes and glitch statistics.
module sync_debounce #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    localparam int CNT_W        = $clog2(STABLE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_async,
    input  logic       glitch_clr,
    output logic       a_clean,
    output logic       rise,
    output logic       fall,
    output logic       glitch,
    output logic [7:0] glitch_cnt
);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        RISE_WAIT = 2'd1,
        HIGH      = 2'd2,
        FALL_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   a_s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rise_d, fall_d, glitch_d;

    // Plain flop chain; a_s is the only synchronised signal the filter looks at.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= {sync_q[SYNC_STAGES-2:0], a_async};
    end

    assign a_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = 1'b0;
        case (state_q)
            LOW: begin
                if (a_s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = HIGH;
                        rise_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = RISE_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            RISE_WAIT: begin
                // Any reversal throws the partial run away entirely.
                if (!a_s) begin
                    state_d  = LOW;
                    glitch_d = 1'b1;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HIGH: begin
                if (!a_s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = LOW;
                        fall_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = FALL_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            FALL_WAIT: begin
                if (a_s) begin
                    state_d  = HIGH;
                    glitch_d = 1'b1;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOW;
            cnt_q   <= '0;
            a_clean <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            glitch  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_clean <= (state_d == HIGH) || (state_d == FALL_WAIT);
            rise    <= rise_d;
            fall    <= fall_d;
            glitch  <= glitch_d;
        end
    end

    // A clear that coincides with a new glitch keeps that glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            glitch_cnt <= 8'd0;
        end else if (glitch_clr) begin
            glitch_cnt <= glitch_d ? 8'd1 : 8'd0;
        end else if (glitch_d && (glitch_cnt != 8'hFF)) begin
            glitch_cnt <= glitch_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce: default instance for latency, bounce and glitch statistics,
// and a SYNC_STAGES=3 / STABLE_CYCLES=1 instance for the short path and mid-operation reset.
module tb_sync_debounce;

    logic       clk;
    logic       rst_a, a_in, clr_a;
    logic       clean_a, rise_a, fall_a, glitch_a;
    logic [7:0] gcnt_a;
    logic       rst_b, b_in, clr_b;
    logic       clean_b, rise_b, fall_b, glitch_b;
    logic [7:0] gcnt_b;

    int n_tests = 0;
    int n_fail  = 0;
    int rise_seen_a = 0, fall_seen_a = 0, glitch_seen_a = 0;
    int rise_seen_b = 0, fall_seen_b = 0;

    sync_debounce dut_a (
        .clk(clk), .rst(rst_a), .a_async(a_in), .glitch_clr(clr_a),
        .a_clean(clean_a), .rise(rise_a), .fall(fall_a), .glitch(glitch_a),
        .glitch_cnt(gcnt_a)
    );

    sync_debounce #(.SYNC_STAGES(3), .STABLE_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst_b), .a_async(b_in), .glitch_clr(clr_b),
        .a_clean(clean_b), .rise(rise_b), .fall(fall_b), .glitch(glitch_b),
        .glitch_cnt(gcnt_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // strobe tallies, sampled away from the active edge
    always @(negedge clk) begin
        rise_seen_a   += int'(rise_a);
        fall_seen_a   += int'(fall_a);
        glitch_seen_a += int'(glitch_a);
        rise_seen_b   += int'(rise_b);
        fall_seen_b   += int'(fall_b);
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // 2-cycle high pulse on dut_a, followed by enough low cycles to abort and settle
    task automatic pulse_a();
        a_in = 1'b1;
        tick(2);
        a_in = 1'b0;
        tick(3);
    endtask

    initial begin
        int r0, f0, g0;
        rst_a = 1'b0; a_in = 1'b0; clr_a = 1'b0;
        rst_b = 1'b0; b_in = 1'b0; clr_b = 1'b0;
        tick(2);
        check("rst_clean", 32'(clean_a), 32'd0);
        check("rst_strobes", 32'({rise_a, fall_a, glitch_a}), 32'd0);
        check("rst_gcnt", 32'(gcnt_a), 32'd0);
        rst_a = 1'b1;
        tick(3);

        // clean rise: edge E1 captures the step, a_clean and rise after E6
        a_in = 1'b1;
        tick(5);
        check("rise_e5_clean", 32'(clean_a), 32'd0);
        tick(1);
        check("rise_e6_clean", 32'(clean_a), 32'd1);
        check("rise_e6_rise", 32'(rise_a), 32'd1);
        tick(1);
        check("rise_e7_rise", 32'(rise_a), 32'd0);
        check("rise_gcnt", 32'(gcnt_a), 32'd0);
        tick(5);

        // clean fall, same latency
        a_in = 1'b0;
        tick(5);
        check("fall_e5_clean", 32'(clean_a), 32'd1);
        tick(1);
        check("fall_e6_fall", 32'(fall_a), 32'd1);
        check("fall_e6_clean", 32'(clean_a), 32'd0);
        check("fall_e6_rg", 32'({rise_a, glitch_a}), 32'd0);
        tick(1);
        check("fall_e7_fall", 32'(fall_a), 32'd0);
        tick(5);

        // short pulse aborts qualification
        g0 = glitch_seen_a; r0 = rise_seen_a;
        a_in = 1'b1;
        tick(2);
        a_in = 1'b0;
        tick(10);
        check("pulse_clean", 32'(clean_a), 32'd0);
        check("pulse_glitch_once", 32'(glitch_seen_a - g0), 32'd1);
        check("pulse_no_rise", 32'(rise_seen_a - r0), 32'd0);
        check("pulse_gcnt", 32'(gcnt_a), 32'd1);

        // bouncy rise: 1,1,0,1,1,1,0 then steady high; rise after E13
        clr_a = 1'b1;
        tick(1);
        clr_a = 1'b0;
        check("clr_gcnt", 32'(gcnt_a), 32'd0);
        g0 = glitch_seen_a; r0 = rise_seen_a;
        a_in = 1'b1; tick(2);
        a_in = 1'b0; tick(1);
        a_in = 1'b1; tick(3);
        a_in = 1'b0; tick(1);
        a_in = 1'b1; tick(5);
        check("bounce_e12_clean", 32'(clean_a), 32'd0);
        tick(1);
        check("bounce_e13_clean", 32'(clean_a), 32'd1);
        check("bounce_e13_rise", 32'(rise_a), 32'd1);
        tick(1);
        check("bounce_e14_rise", 32'(rise_a), 32'd0);
        tick(5);
        check("bounce_gcnt", 32'(gcnt_a), 32'd2);
        check("bounce_glitches", 32'(glitch_seen_a - g0), 32'd2);
        check("bounce_one_rise", 32'(rise_seen_a - r0), 32'd1);

        // saturation
        a_in = 1'b0;
        tick(10);
        for (int i = 0; i < 300; i++) pulse_a();
        tick(5);
        check("sat_gcnt", 32'(gcnt_a), 32'd255);
        check("sat_clean", 32'(clean_a), 32'd0);

        // clear alone, then constant input produces nothing
        clr_a = 1'b1;
        tick(1);
        clr_a = 1'b0;
        check("clr_alone", 32'(gcnt_a), 32'd0);
        r0 = rise_seen_a; f0 = fall_seen_a; g0 = glitch_seen_a;
        tick(20);
        check("idle_strobes", 32'((rise_seen_a - r0) + (fall_seen_a - f0) + (glitch_seen_a - g0)), 32'd0);
        check("idle_gcnt", 32'(gcnt_a), 32'd0);

        // clear coincident with a glitch: glitch registers at E5 of the pulse
        pulse_a();
        pulse_a();
        check("pre_coinc_gcnt", 32'(gcnt_a), 32'd2);
        a_in = 1'b1; tick(2);
        a_in = 1'b0; tick(2);
        clr_a = 1'b1;
        tick(1);
        clr_a = 1'b0;
        check("coinc_glitch", 32'(glitch_a), 32'd1);
        check("coinc_gcnt", 32'(gcnt_a), 32'd1);
        tick(5);
        check("coinc_gcnt_hold", 32'(gcnt_a), 32'd1);

        // SYNC_STAGES=3, STABLE_CYCLES=1: rise after E4
        rst_b = 1'b1;
        tick(3);
        b_in = 1'b1;
        tick(3);
        check("b_e3_clean", 32'(clean_b), 32'd0);
        tick(1);
        check("b_e4_clean", 32'(clean_b), 32'd1);
        check("b_e4_rise", 32'(rise_b), 32'd1);
        tick(1);
        check("b_e5_rise", 32'(rise_b), 32'd0);
        tick(3);

        // asynchronous reset mid-HIGH with input still high
        f0 = fall_seen_b; r0 = rise_seen_b;
        #2;
        rst_b = 1'b0;
        #1;
        check("b_rst_clean", 32'(clean_b), 32'd0);
        check("b_rst_strobes", 32'({rise_b, fall_b, glitch_b}), 32'd0);
        check("b_rst_gcnt", 32'(gcnt_b), 32'd0);
        tick(2);
        check("b_rst_hold_clean", 32'(clean_b), 32'd0);
        rst_b = 1'b1;
        tick(3);
        check("b_rel_e3_clean", 32'(clean_b), 32'd0);
        tick(1);
        check("b_rel_e4_clean", 32'(clean_b), 32'd1);
        check("b_rel_e4_rise", 32'(rise_b), 32'd1);
        tick(1);
        check("b_rel_e5_rise", 32'(rise_b), 32'd0);
        check("b_rst_no_fall", 32'(fall_seen_b - f0), 32'd0);
        check("b_rel_one_rise", 32'(rise_seen_b - r0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_debounce.md
Name: sync_debounce

Overview:
- Input-conditioning stage placed directly upstream of the edge and pulse detectors.
- Takes an asynchronous, bouncy input and synchronises it into clk.
- Filters it so a level change is accepted only after it has been stable for STABLE_CYCLES consecutive cycles.
- Outputs the clean level, registered rise/fall strobes and glitch statistics that downstream detectors consume.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops; legal values are 2 or more.
- STABLE_CYCLES, 4, number of consecutive synchronised samples needed to accept a new level; legal values are 1 or more.
- CNT_W, $clog2(STABLE_CYCLES+1), width of the stability counter; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- a_async  input  1  raw, unsynchronised input.
- glitch_clr  input  1  synchronous clear of glitch_cnt.
- a_clean  output  1  debounced, synchronised level.
- rise  output  1  one-cycle strobe on an accepted 0->1 change.
- fall  output  1  one-cycle strobe on an accepted 1->0 change.
- glitch  output  1  one-cycle strobe when a candidate change is aborted.
- glitch_cnt  output  8  saturating count of glitch events.

Behaviour:
- Reset (rst low): asynchronously clears all of the following immediately, and they stay cleared while rst is low:
  - synchroniser flops
  - FSM state (set to LOW)
  - stability counter
  - a_clean, rise, fall, glitch, glitch_cnt (all outputs 0).
- Synchroniser: a SYNC_STAGES-deep flop chain with no logic between stages. a_s is the last stage and the only signal the FSM reads.
- FSM states: LOW, RISE_WAIT, HIGH, FALL_WAIT. a_clean is 1 in HIGH and FALL_WAIT, and 0 in LOW and RISE_WAIT. All outputs are registered.
- LOW:
  - a_s=1 -> RISE_WAIT with cnt=1.
  - If STABLE_CYCLES==1, go directly to HIGH instead.
- RISE_WAIT:
  - a_s=0 -> LOW; glitch=1 for one cycle.
  - a_s=1 and cnt==STABLE_CYCLES-1 -> HIGH.
  - Otherwise cnt+1.
- HIGH and FALL_WAIT: mirror of LOW and RISE_WAIT with a_s inverted.
  - FALL_WAIT abort (a_s=1) -> HIGH with glitch=1.
- rise is 1 exactly in the first cycle a_clean is 1. fall is 1 exactly in the first cycle a_clean is 0 after HIGH/FALL_WAIT.
- rise, fall and glitch are never 1 in the same cycle, and never 1 in two consecutive cycles for the same event.
- Latency: a_async goes high and stays high, first captured at edge E1. a_clean, together with rise, goes high after edge E(SYNC_STAGES+STABLE_CYCLES); with defaults that is edge E6. The fall path has identical latency.
- Bounce handling: any a_s reversal inside a WAIT state restarts qualification from LOW/HIGH. A new candidate needs a full STABLE_CYCLES run; partial runs never accumulate.
- glitch_cnt:
  - Increments by 1 on each glitch strobe and saturates at 255 (no wrap).
  - glitch_clr=1 sets it to 0.
  - glitch_clr and a glitch event in the same cycle: result is 1, so the event is not lost.
- Reset mid-operation: any pending qualification is discarded. After release, the FSM starts in LOW regardless of a_async.
  - If the input is held high, a_clean rises with a rise strobe SYNC_STAGES+STABLE_CYCLES edges after release.
  - No fall strobe is generated by reset itself.
- Input held constant for any length of time: no strobes and no counter change.

Test Plan:
- Defaults, reset released, a_async steps 0->1 at edge E1 and holds -> a_clean=1 and rise=1 after edge E6; rise=0 after E7; glitch_cnt=0.
- a_clean=1, a_async drops to 0 and holds -> fall=1 for one cycle, a_clean=0, six edges after the first sampling edge; rise and glitch stay 0.
- a_clean=0, a_async pulses high for exactly 2 cycles, then low -> a_clean stays 0; glitch=1 once; glitch_cnt=1.
- Bouncy rise: high 2 cycles, low 1, high 3, low 1, then high steady -> glitch_cnt=2; a_clean rises once with a single rise strobe, 4 stable samples after the final high edge reaches a_s.
- 300 aborted 2-cycle pulses -> glitch_cnt saturates at 255.
  - glitch_clr asserted alone -> glitch_cnt=0.
  - glitch_clr coincident with a glitch -> glitch_cnt=1.
- STABLE_CYCLES=1, SYNC_STAGES=3:
  - step high -> a_clean and rise after edge E4.
  - a_async held high, rst pulsed low mid-HIGH -> all outputs 0 immediately; after release, rise reappears after 4 edges.
